// File: rtl/fsm_timed_pkg.sv
// Shared types and default timing constants for the button-to-enable front end.
`default_nettype none

package fsm_timed_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DB_PRESS  = 3'd1,
    PRESSED   = 3'd2,
    LONG_HELD = 3'd3,
    DB_REL    = 3'd4
  } btn_state_t;

  localparam int BTN_DB_CYCLES   = 4;
  localparam int BTN_LONG_CYCLES = 64;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/btn_enable_ctrl.sv
// Debounced push-button controller: short press toggles enable, long press clears it.
`default_nettype none

module btn_enable_ctrl
  import fsm_timed_pkg::*;
#(
  parameter int DB_CYCLES   = BTN_DB_CYCLES,
  parameter int LONG_CYCLES = BTN_LONG_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic enable,
  output logic press_pulse,
  output logic long_press
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_MAX     = '1;

  logic             btn_s;
  btn_state_t       state;
  btn_state_t       next_state;
  logic [CNT_W-1:0] t;
  logic             was_long;
  logic             short_done;
  logic             long_hit;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (btn_s) next_state = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s)            next_state = IDLE;
        else if (t == DB_LAST) next_state = PRESSED;
      end
      PRESSED: begin
        if (!btn_s)              next_state = DB_REL;
        else if (t == LONG_LAST) next_state = LONG_HELD;
      end
      LONG_HELD: begin
        if (!btn_s) next_state = DB_REL;
      end
      DB_REL: begin
        // A release bounce resumes whichever held state the press had reached.
        if (btn_s)             next_state = was_long ? LONG_HELD : PRESSED;
        else if (t == DB_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    short_done = (state == DB_REL) && (next_state == IDLE) && !was_long;
    long_hit   = (state == PRESSED) && (next_state == LONG_HELD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      t           <= '0;
      was_long    <= 1'b0;
      enable      <= 1'b0;
      press_pulse <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state) t <= '0;
      else if (t != T_MAX)     t <= t + 1'b1;

      if (long_hit)                 was_long <= 1'b1;
      else if (next_state == IDLE)  was_long <= 1'b0;

      if (long_hit)        enable <= 1'b0;
      else if (short_done) enable <= ~enable;

      press_pulse <= short_done;
      long_press  <= long_hit;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_enable_ctrl.sv
// Scoreboard bench for btn_enable_ctrl using a run-length reference model.
`default_nettype none

module tb_btn_enable_ctrl;

  localparam int DB   = 4;
  localparam int LONG = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic enable, press_pulse, long_press;

  btn_enable_ctrl #(
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .enable      (enable),
    .press_pulse (press_pulse),
    .long_press  (long_press)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic en;
    logic pp;
    logic lp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses_seen = 0;

  // Reference model: the debounced level changes only after the synchronised
  // input has disagreed with it for DB+1 consecutive edges; a press becomes long
  // after LONG uninterrupted accepted-held edges.
  bit m_s1, m_s2;
  bit deb, was_long, m_en;
  int cand, held;

  task automatic model_edge(input bit raw, input bit r);
    bit   b;
    exp_t e;
    e.pp = 1'b0;
    e.lp = 1'b0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; deb = 0; cand = 0; held = 0; was_long = 0; m_en = 0;
    end else begin
      b    = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      if (b != deb) begin
        cand++;
        if (cand > DB) begin
          cand = 0;
          deb  = b;
          if (b) held = 0;
          else begin
            if (!was_long) begin
              m_en = !m_en;
              e.pp = 1'b1;
            end
            was_long = 0;
          end
        end
      end else begin
        if (deb && cand > 0) held = 0;
        else if (deb && !was_long) begin
          if (held == LONG - 1) begin
            e.lp = 1'b1;
            m_en = 0;
            was_long = 1;
          end else held++;
        end
        cand = 0;
      end
    end
    e.en = m_en;
    sb.push_back(e);
  endtask

  task automatic tick(input bit raw, input bit r);
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    model_edge(raw, r);
    #1;
  endtask

  task automatic hold(input bit raw, input int n);
    for (int i = 0; i < n; i++) tick(raw, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (enable !== e.en) begin
        miscompares++;
        $display("FAIL enable @%0t: got %b expected %b", $time, enable, e.en);
      end
      vectors++;
      if (press_pulse !== e.pp) begin
        miscompares++;
        $display("FAIL press_pulse @%0t: got %b expected %b", $time, press_pulse, e.pp);
      end
      vectors++;
      if (long_press !== e.lp) begin
        miscompares++;
        $display("FAIL long_press @%0t: got %b expected %b", $time, long_press, e.lp);
      end
      if (e.pp || e.lp) pulses_seen++;
    end
  end

  initial begin
    // Reset held with the button pressed, then released.
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    hold(1'b0, 12);
    // Two short presses: enable toggles up then down.
    hold(1'b1, 10); hold(1'b0, 12);
    hold(1'b1, 10); hold(1'b0, 12);
    // Glitches that must be rejected.
    hold(1'b1, 1); hold(1'b0, 8);
    hold(1'b1, 3); hold(1'b0, 8);
    hold(1'b1, 4); hold(1'b0, 8);
    // Set enable, then long press clears it; release does nothing.
    hold(1'b1, 10); hold(1'b0, 12);
    hold(1'b1, 40); hold(1'b0, 12);
    // Release bounce back into PRESSED, single pulse on final release.
    hold(1'b1, 10); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 12);
    // Release bounce then hold long enough to go long from the restart point.
    hold(1'b1, 10); hold(1'b0, 2); hold(1'b1, 22); hold(1'b0, 2);
    hold(1'b1, 3); hold(1'b0, 12);
    // Reset while in release debounce: no toggle.
    hold(1'b1, 10); hold(1'b0, 4);
    tick(1'b0, 1'b1);
    hold(1'b0, 12);
    // Randomised run lengths biased around the debounce and long thresholds.
    for (int i = 0; i < 300; i++) begin
      int n;
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(1, DB + 2);
        1:       n = $urandom_range(DB + 3, 12);
        2:       n = $urandom_range(LONG - 2, LONG + 10);
        default: n = $urandom_range(1, 30);
      endcase
      hold(i[0] ? 1'b0 : 1'b1, n);
      if ($urandom_range(0, 60) == 0) tick(1'b0, 1'b1);
    end
    hold(1'b0, 12);
    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    vectors++;
    if (pulses_seen < 10) begin
      miscompares++;
      $display("FAIL pulse_activity: got %0d pulses expected at least 10", pulses_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
